// File: rtl/full_adder_gate.sv
// Gate-level full adder with a registered copy of its outputs, a saturating
// carry counter and a sticky arithmetic self-check.
module full_adder_gate (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       Cin,
    output wire        S,
    output wire        Cout,
    output logic       S_q,
    output logic       Cout_q,
    output logic       valid_q,
    output logic [7:0] carry_cnt,
    output logic       err
);

    wire a_xor_b;
    wire a_and_b;
    wire cin_and_axb;

    xor g_xor_ab  (a_xor_b, A, B);
    xor g_xor_sum (S, a_xor_b, Cin);
    and g_and_ab  (a_and_b, A, B);
    and g_and_cin (cin_and_axb, Cin, a_xor_b);
    or  g_or_cout (Cout, a_and_b, cin_and_axb);

    logic [1:0] ref_sum;
    logic [7:0] carry_cnt_d;
    logic       err_d;

    // Behavioural reference, deliberately independent of the gate netlist.
    always_comb begin
        ref_sum = {1'b0, A} + {1'b0, B} + {1'b0, Cin};
        err_d   = err | ({Cout, S} != ref_sum);
        carry_cnt_d = carry_cnt;
        if (Cout && (carry_cnt != 8'hFF)) begin
            carry_cnt_d = carry_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S_q       <= 1'b0;
            Cout_q    <= 1'b0;
            valid_q   <= 1'b0;
            carry_cnt <= 8'h00;
            err       <= 1'b0;
        end else begin
            S_q       <= S;
            Cout_q    <= Cout;
            valid_q   <= 1'b1;
            carry_cnt <= carry_cnt_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_full_adder_gate.sv
// Scoreboard bench for full_adder_gate: the driver pushes expected registered
// results, a monitor pops and compares one entry per non-reset clock edge.
module tb_full_adder_gate;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b0;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       Cin = 1'b0;
    wire        S;
    wire        Cout;
    logic       S_q;
    logic       Cout_q;
    logic       valid_q;
    logic [7:0] carry_cnt;
    logic       err;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       s;
        logic       c;
        logic       e;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] cnt_m = 8'h00;
    logic       err_m = 1'b0;

    full_adder_gate dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .S_q       (S_q),
        .Cout_q    (Cout_q),
        .valid_q   (valid_q),
        .carry_cnt (carry_cnt),
        .err       (err)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // One clock edge with rst_n=1; inj forces Cout low to exercise the self-check.
    task automatic step(input logic a, input logic b, input logic c, input logic inj);
        logic [1:0] r;
        logic       co;
        exp_t       e;
        @(negedge clk);
        if (inj) force dut.Cout = 1'b0;
        else release dut.Cout;
        rst_n = 1'b1;
        A = a; B = b; Cin = c;
        r  = {1'b0, a} + {1'b0, b} + {1'b0, c};
        co = inj ? 1'b0 : r[1];
        if (co && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
        if ({co, r[0]} != r) err_m = 1'b1;
        e.s = r[0]; e.c = co; e.e = err_m; e.cnt = cnt_m;
        sb.push_back(e);
        #1;
        if (!inj) check("comb", {10'd0, S, Cout}, {10'd0, r[0], r[1]});
    endtask

    task automatic rst_step(input logic a, input logic b, input logic c);
        @(negedge clk);
        release dut.Cout;
        rst_n = 1'b0;
        A = a; B = b; Cin = c;
        cnt_m = 8'h00;
        err_m = 1'b0;
    endtask

    // Monitor: reset edges must clear everything, other edges pop the scoreboard.
    logic rs;
    exp_t me;
    always @(posedge clk) begin
        rs = rst_n;
        #1;
        if (!rs) begin
            check("reset_state", {valid_q, S_q, Cout_q, err, carry_cnt}, 12'h000);
        end else if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_empty: got result with no expectation, expected queued entry");
        end else begin
            me = sb.pop_front();
            check("registered", {valid_q, S_q, Cout_q, err, carry_cnt},
                  {1'b1, me.s, me.c, me.e, me.cnt});
        end
    end

    logic [1:0] tt_exp [8];

    initial begin
        // {S,Cout} for A,B,Cin = 000..111
        tt_exp[0] = 2'b00; tt_exp[1] = 2'b10; tt_exp[2] = 2'b10; tt_exp[3] = 2'b01;
        tt_exp[4] = 2'b10; tt_exp[5] = 2'b01; tt_exp[6] = 2'b01; tt_exp[7] = 2'b11;

        for (int i = 0; i < 8; i++) begin
            {A, B, Cin} = 3'(i);
            #10;
            check($sformatf("truth_%0d", i), {10'd0, S, Cout}, {10'd0, tt_exp[i]});
        end

        clk_en = 1'b1;
        rst_step(1'b0, 1'b0, 1'b0);
        rst_step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("saturate", {1'b0, S_q, Cout_q, 1'b0, carry_cnt}, {4'b0110, 8'd255});

        rst_step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b0;
        A = 1'b0; B = 1'b1; Cin = 1'b1;
        cnt_m = 8'h00;
        err_m = 1'b0;
        #1;
        check("rst_no_edge", {valid_q, S, Cout, 1'b0, carry_cnt}, {4'b1010, 8'd10});
        @(posedge clk);
        #2;
        A = 1'b1; B = 1'b0; Cin = 1'b0;
        #1;
        check("comb_in_reset", {10'd0, S, Cout}, {10'd0, 2'b10});

        for (int i = 0; i < 8; i++) step(i[2], i[1], i[0], 1'b0);
        @(posedge clk);
        #2;
        check("selfcheck_clean", {11'd0, err}, 12'd0);

        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("err_sticky", {11'd0, err}, 12'd1);

        rst_step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clk_en = 1'b0;
        #20;
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/full_adder_gate.md
FULL_ADDER_GATE -- requirements
Module: full_adder_gate

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset; the ports are clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all registered logic.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 A  input  1  addend bit.
REQ-006 B  input  1  addend bit.
REQ-007 Cin  input  1  carry-in bit.
REQ-008 S  output  1  combinational sum bit.
REQ-009 Cout  output  1  combinational carry-out bit.
REQ-010 S_q  output  1  registered copy of S.
REQ-011 Cout_q  output  1  registered copy of Cout.
REQ-012 valid_q  output  1  high when S_q/Cout_q hold a result captured since the last reset.
REQ-013 carry_cnt  output  8  saturating count of rising clock edges on which Cout was 1.
REQ-014 err  output  1  sticky mismatch flag from the internal self-check.

Function
REQ-015 S SHALL equal A XOR B XOR Cin.
REQ-016 Cout SHALL equal (A AND B) OR (Cin AND (A XOR B)).
REQ-017 S and Cout SHALL be built as a gate-level netlist: two XOR, two AND and one OR primitive.
REQ-018 S and Cout SHALL be purely combinational, with zero-cycle latency, and SHALL be independent of clk and rst_n.
REQ-019 S and Cout SHALL settle within the same simulation time step as any input change, with no X once all inputs are known.
REQ-020 On each rising clk edge with rst_n=1, S_q and Cout_q SHALL capture S and Cout (1-cycle latency).
REQ-021 valid_q SHALL become 1 on the first rising clk edge with rst_n=1 after reset and SHALL stay 1 until the next reset.
REQ-022 On each rising edge with rst_n=1 and Cout=1, carry_cnt SHALL increment by 1.
REQ-023 carry_cnt SHALL saturate at 255 and SHALL not wrap.
REQ-024 The internal self-check SHALL compute the reference value {Cout_ref,S_ref} = A + B + Cin as a 2-bit sum.
REQ-025 On each rising edge with rst_n=1, err SHALL be set if {Cout,S} differs from {Cout_ref,S_ref}.
REQ-026 Once set, err SHALL remain 1 until reset.
REQ-027 If inputs change between clock edges, only the values present at the rising edge SHALL be captured.

Reset
REQ-028 When rst_n=0 at a rising clk edge, S_q, Cout_q, valid_q and err SHALL be 0 and carry_cnt SHALL be 0x00.
REQ-029 Reset SHALL take priority over capture, counting and error setting on the same edge.
REQ-030 Assertion of rst_n with no clock edge SHALL not change any registered output.
REQ-031 Reset SHALL not affect S or Cout.

Verification
REQ-032 Exhaustive truth table: apply A,B,Cin = 000 through 111, 10 time units apart, with no clock running -> S,Cout = 00,10,10,01,10,01,01,11.
REQ-033 Registered path: hold rst_n=0 for 2 clocks, then set rst_n=1 with A,B,Cin=1,1,0 -> after 1 edge, S_q=0, Cout_q=1 and valid_q=1; before that edge, all registered outputs = 0.
REQ-034 Carry count saturation: hold A=B=Cin=1 for 300 clocks -> carry_cnt = 255 and S_q=1, Cout_q=1.
REQ-035 Reset mid-operation: with carry_cnt=10 and valid_q=1, drive rst_n=0 for one edge -> all registered outputs = 0 at that edge, while S and Cout still track the inputs.
REQ-036 Self-check: clock all 8 input combinations -> err stays 0; with Cout forced to 0 while A,B,Cin=1,1,1 -> err = 1 after the next edge and stays 1 until reset.
